// File: rtl/decode_ctrl_sched_if.sv
// decode_ctrl_sched_if: ID-stage decode/control bundle between the decode controller and its neighbours
// Ports (via modports):
//   master drives instr_d, valid_d, flush_e and observes the decoded and registered EX controls
//   slave  is the decode controller: consumes ID inputs, produces ImmSrc/ins_immediate,
//          stall_f/stall_d, illegal_d, the ID/EX control register and stall_cnt
interface decode_ctrl_sched_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_d;
    logic             valid_d;
    logic             flush_e;
    logic [2:0]       ImmSrc;
    logic [20:0]      ins_immediate;
    logic             stall_f;
    logic             stall_d;
    logic             illegal_d;
    logic             reg_write_e;
    logic             mem_write_e;
    logic             mem_read_e;
    logic             alu_src_e;
    logic             branch_e;
    logic             jump_e;
    logic [1:0]       result_src_e;
    logic [4:0]       rd_e;
    logic             valid_e;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output instr_d, valid_d, flush_e,
        input  ImmSrc, ins_immediate, stall_f, stall_d, illegal_d,
               reg_write_e, mem_write_e, mem_read_e, alu_src_e, branch_e, jump_e,
               result_src_e, rd_e, valid_e, stall_cnt
    );
    modport slave (
        input  instr_d, valid_d, flush_e,
        output ImmSrc, ins_immediate, stall_f, stall_d, illegal_d,
               reg_write_e, mem_write_e, mem_read_e, alu_src_e, branch_e, jump_e,
               result_src_e, rd_e, valid_e, stall_cnt
    );
endinterface

// File: rtl/decode_ctrl_sched.sv
// decode_ctrl_sched: RISC-V ID-stage decoder, ID/EX control register and load-use stall sequencer
// Ports:
//   clk, rst    core clock (rising edge), asynchronous active-high reset
//   bus (slave) instr_d/valid_d/flush_e in; ImmSrc, ins_immediate, illegal_d (combinational);
//               stall_f/stall_d (combinational); registered EX controls, rd_e, valid_e; stall_cnt
// Optional feature: define STALL_COUNT_EN to get a saturating stall_d cycle counter on stall_cnt;
//   otherwise stall_cnt is tied to 0.
module decode_ctrl_sched #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    decode_ctrl_sched_if.slave  bus
);
    typedef enum logic {RUN, STALL} state_t;
    state_t state, state_nx;
    logic [31:0] ins;
    logic [2:0]  imm_src;
    logic [1:0]  result_src;
    logic        reg_write, mem_write, mem_read, alu_src, branch, jump;
    logic        illegal, use_rs1, use_rs2, has_imm;
    logic        hz, stall, bubble;
    logic        unused_ok;
    assign ins = bus.instr_d;
    // funct3 and XLEN do not influence opcode-level decode
    assign unused_ok = ^{ins[14:12], XLEN == 32};
    always_comb begin
        imm_src    = 3'b000;
        result_src = 2'b00;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        illegal    = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        has_imm    = 1'b1;
        case (ins[6:0])
            7'b0000011: begin reg_write = 1'b1; mem_read = 1'b1; alu_src = 1'b1; result_src = 2'b01; use_rs1 = 1'b1; end
            7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; use_rs1 = 1'b1; end
            7'b1100111: begin reg_write = 1'b1; jump = 1'b1; result_src = 2'b10; use_rs1 = 1'b1; end
            7'b0100011: begin imm_src = 3'b001; mem_write = 1'b1; alu_src = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0110011: begin reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; has_imm = 1'b0; end
            7'b1100011: begin imm_src = 3'b010; branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0110111,
            7'b0010111: begin imm_src = 3'b011; reg_write = 1'b1; alu_src = 1'b1; end
            7'b1101111: begin imm_src = 3'b100; reg_write = 1'b1; jump = 1'b1; result_src = 2'b10; end
            default:    begin illegal = 1'b1; has_imm = 1'b0; end
        endcase
    end
    // R-type shares ImmSrc 000 with I-type, so has_imm is what zeroes its packed field
    always_comb begin
        bus.ins_immediate = '0;
        if (has_imm)
            case (imm_src)
                3'b000:  bus.ins_immediate = {9'b0, ins[31:20]};
                3'b001:  bus.ins_immediate = {9'b0, ins[31:25], ins[11:7]};
                3'b010:  bus.ins_immediate = {8'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                3'b011:  bus.ins_immediate = {1'b0, ins[31:12]};
                default: bus.ins_immediate = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            endcase
    end
    assign bus.ImmSrc    = imm_src;
    assign bus.illegal_d = illegal & bus.valid_d;
    // A bubble already in EX clears valid_e, so the held instruction never re-triggers in STALL
    assign hz = bus.valid_d & bus.valid_e & bus.mem_read_e & (bus.rd_e != 5'd0) &
                ((use_rs1 & (ins[19:15] == bus.rd_e)) | (use_rs2 & (ins[24:20] == bus.rd_e)));
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= RUN;
        else     state <= state_nx;
    always_comb
        state_nx = bus.flush_e ? RUN : ((state == RUN) && hz) ? STALL : RUN;
    always_comb begin
        stall       = (state == RUN) & hz & ~bus.flush_e;
        bus.stall_f = stall;
        bus.stall_d = stall;
    end
    assign bubble = bus.flush_e | ((state == RUN) & hz) | ~bus.valid_d | illegal;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            bus.reg_write_e  <= 1'b0;
            bus.mem_write_e  <= 1'b0;
            bus.mem_read_e   <= 1'b0;
            bus.alu_src_e    <= 1'b0;
            bus.branch_e     <= 1'b0;
            bus.jump_e       <= 1'b0;
            bus.result_src_e <= 2'b00;
            bus.rd_e         <= 5'd0;
            bus.valid_e      <= 1'b0;
        end else begin
            bus.reg_write_e  <= reg_write;
            bus.mem_write_e  <= mem_write;
            bus.mem_read_e   <= mem_read;
            bus.alu_src_e    <= alu_src;
            bus.branch_e     <= branch;
            bus.jump_e       <= jump;
            bus.result_src_e <= result_src;
            bus.rd_e         <= ins[11:7];
            bus.valid_e      <= 1'b1;
        end
    end
`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst)                      cnt <= '0;
        else if (stall && (~&cnt))    cnt <= cnt + 1'b1;
    assign bus.stall_cnt = cnt;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_decode_ctrl_sched.sv
// tb_decode_ctrl_sched: directed self-checking bench for decode_ctrl_sched
module tb_decode_ctrl_sched;
    localparam logic [31:0] BEQ  = 32'hFE010EE3;
    localparam logic [31:0] LW5  = 32'h0000A283;
    localparam logic [31:0] ADD  = 32'h00228333;
    localparam logic [31:0] LW0  = 32'h0000A003;
    localparam logic [31:0] ADD0 = 32'h00000333;
    localparam logic [31:0] LUI5 = 32'h000282B7;
    localparam logic [31:0] SW   = 32'h0020A423;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BAD  = 32'hFFFFFFFF;
`ifdef STALL_COUNT_EN
    localparam logic [31:0] CNT3 = 3, CNT5 = 5, CNT_SAT = 3;
`else
    localparam logic [31:0] CNT3 = 0, CNT5 = 0, CNT_SAT = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    decode_ctrl_sched_if #(.CNT_W(16)) bus ();
    decode_ctrl_sched_if #(.CNT_W(2))  bus2 ();
    decode_ctrl_sched #(.XLEN(32), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    decode_ctrl_sched #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    assign bus2.instr_d = bus.instr_d;
    assign bus2.valid_d = bus.valid_d;
    assign bus2.flush_e = bus.flush_e;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic drive(input logic [31:0] i, input logic v, input logic f);
        bus.instr_d = i;
        bus.valid_d = v;
        bus.flush_e = f;
        #1;
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        drive(32'h0, 1'b0, 1'b0);
        #11;
        check("rst_valid_e", 32'(bus.valid_e), 0);
        check("rst_rd_e", 32'(bus.rd_e), 0);
        check("rst_stall_d", 32'(bus.stall_d), 0);
        check("rst_cnt", 32'(bus.stall_cnt), 0);
        rst = 1'b0;
        tick;
        drive(BEQ, 1'b1, 1'b0);
        check("beq_immsrc", 32'(bus.ImmSrc), 2);
        check("beq_imm", 32'(bus.ins_immediate), 32'h01FFC);
        check("beq_illegal", 32'(bus.illegal_d), 0);
        tick;
        check("beq_branch_e", 32'(bus.branch_e), 1);
        check("beq_valid_e", 32'(bus.valid_e), 1);
        check("beq_rd_e", 32'(bus.rd_e), 29);
        check("beq_regwr_e", 32'(bus.reg_write_e), 0);
        drive(LW5, 1'b1, 1'b0);
        tick;
        check("lw_memrd_e", 32'(bus.mem_read_e), 1);
        check("lw_res_e", 32'(bus.result_src_e), 1);
        check("lw_rd_e", 32'(bus.rd_e), 5);
        drive(ADD, 1'b1, 1'b0);
        check("lu_stall_f", 32'(bus.stall_f), 1);
        check("lu_stall_d", 32'(bus.stall_d), 1);
        tick;
        check("lu_bubble", 32'(bus.valid_e), 0);
        check("lu_bubble_rd", 32'(bus.rd_e), 0);
        check("lu_one_stall", 32'(bus.stall_d), 0);
        tick;
        check("lu_add_valid", 32'(bus.valid_e), 1);
        check("lu_add_rd", 32'(bus.rd_e), 6);
        check("lu_add_regwr", 32'(bus.reg_write_e), 1);
        check("lu_add_memrd", 32'(bus.mem_read_e), 0);
        drive(LW0, 1'b1, 1'b0);
        tick;
        check("lw0_memrd", 32'(bus.mem_read_e), 1);
        drive(ADD0, 1'b1, 1'b0);
        check("x0_no_stall", 32'(bus.stall_d), 0);
        tick;
        check("x0_add_valid", 32'(bus.valid_e), 1);
        drive(LW5, 1'b1, 1'b0);
        tick;
        drive(LUI5, 1'b1, 1'b0);
        check("lui_no_stall", 32'(bus.stall_d), 0);
        check("lui_immsrc", 32'(bus.ImmSrc), 3);
        check("lui_imm", 32'(bus.ins_immediate), 32'h28);
        tick;
        check("lui_valid", 32'(bus.valid_e), 1);
        check("lui_alusrc", 32'(bus.alu_src_e), 1);
        drive(LW5, 1'b1, 1'b0);
        tick;
        drive(ADD, 1'b1, 1'b1);
        check("fl_stall_f", 32'(bus.stall_f), 0);
        check("fl_stall_d", 32'(bus.stall_d), 0);
        tick;
        check("fl_bubble", 32'(bus.valid_e), 0);
        drive(ADD, 1'b1, 1'b0);
        check("fl_no_stall_next", 32'(bus.stall_d), 0);
        tick;
        check("fl_add_rd", 32'(bus.rd_e), 6);
        drive(SW, 1'b1, 1'b0);
        check("sw_immsrc", 32'(bus.ImmSrc), 1);
        check("sw_imm", 32'(bus.ins_immediate), 8);
        tick;
        check("sw_memwr", 32'(bus.mem_write_e), 1);
        check("sw_regwr", 32'(bus.reg_write_e), 0);
        drive(JAL, 1'b1, 1'b0);
        check("jal_immsrc", 32'(bus.ImmSrc), 4);
        check("jal_imm", 32'(bus.ins_immediate), 8);
        tick;
        check("jal_jump", 32'(bus.jump_e), 1);
        check("jal_res", 32'(bus.result_src_e), 2);
        drive(BAD, 1'b1, 1'b0);
        check("ill_flag", 32'(bus.illegal_d), 1);
        check("ill_imm", 32'(bus.ins_immediate), 0);
        check("ill_immsrc", 32'(bus.ImmSrc), 0);
        tick;
        check("ill_bubble", 32'(bus.valid_e), 0);
        check("ill_regwr", 32'(bus.reg_write_e), 0);
        drive(ADD, 1'b0, 1'b0);
        check("inv_illegal", 32'(bus.illegal_d), 0);
        tick;
        check("inv_bubble", 32'(bus.valid_e), 0);
        drive(LW5, 1'b1, 1'b0);
        tick;
        drive(ADD, 1'b1, 1'b0);
        check("rs_pre_stall", 32'(bus.stall_d), 1);
        rst = 1'b1;
        #1;
        check("rs_stall_d", 32'(bus.stall_d), 0);
        check("rs_valid_e", 32'(bus.valid_e), 0);
        check("rs_rd_e", 32'(bus.rd_e), 0);
        check("rs_memrd", 32'(bus.mem_read_e), 0);
        rst = 1'b0;
        drive(ADDI, 1'b1, 1'b0);
        check("addi_immsrc", 32'(bus.ImmSrc), 0);
        check("addi_imm", 32'(bus.ins_immediate), 5);
        tick;
        check("addi_rd", 32'(bus.rd_e), 1);
        check("addi_regwr", 32'(bus.reg_write_e), 1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(LW5, 1'b1, 1'b0);
            tick;
            drive(ADD, 1'b1, 1'b0);
            tick;
            tick;
            if (k == 2) check("cnt_3", 32'(bus.stall_cnt), CNT3);
        end
        check("cnt_5", 32'(bus.stall_cnt), CNT5);
        check("cnt_sat", 32'(bus2.stall_cnt), CNT_SAT);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_ctrl_sched.md
Name: decode_ctrl_sched

Overview:
- Decode-stage controller of the 5-stage RISC-V core.
- Decodes the ID-stage opcode into the immediate-type select and the 21-bit packed immediate field consumed by the immediate extender.
- Owns the ID/EX control pipeline register.
- Detects load-use hazards, sequencing one-cycle stalls and bubble insertion via a small FSM; honours branch/jump flushes from EX.

Parameters:
- XLEN, 32, datapath width (instruction width fixed at 32).
- CNT_W, 16, width of optional stall counter.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_d  in  32  instruction in ID stage
- valid_d  in  1  instr_d holds a real instruction
- flush_e  in  1  taken branch/jump resolved in EX; squash ID
- ImmSrc  out  3  immediate type to extender (combinational): 000 I, 001 S, 010 B, 011 U, 100 J
- ins_immediate  out  21  packed immediate to extender (combinational), unused MSBs zero
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID
- illegal_d  out  1  unknown opcode with valid_d (combinational)
- reg_write_e, mem_write_e, mem_read_e, alu_src_e, branch_e, jump_e  out  1 each  registered EX controls
- result_src_e  out  2  00 ALU, 01 mem, 10 PC+4
- rd_e  out  5  registered destination register
- valid_e  out  1  EX slot holds a real instruction
- stall_cnt  out  CNT_W  optional, see below

Behaviour:
- Combinational decode by opcode instr_d[6:0]:
  - 0000011 lw: I, reg_write, mem_read, alu_src, result 01
  - 0010011 I-ALU: I, reg_write, alu_src
  - 1100111 jalr: I, reg_write, jump, result 10
  - 0100011 sw: S, mem_write, alu_src
  - 0110011 R-type: ImmSrc 000 (don't-care), reg_write
  - 1100011 branch: B, branch
  - 0110111 lui / 0010111 auipc: U, reg_write, alu_src
  - 1101111 jal: J, reg_write, jump, result 10
  - Any other opcode: illegal, all controls 0, ImmSrc 000.
- ins_immediate packing:
  - I: [11:0]=instr[31:20]
  - S: [11:0]={instr[31:25],instr[11:7]}
  - B: [12:0]={instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
  - U: [19:0]=instr[31:12]
  - J: [20:0]={instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
  - R-type and illegal: 0.
- Register-use flags:
  - rs1 used: all types except lui, auipc, jal.
  - rs2 used: R-type, sw, branch.
- Hazard condition: hz = valid_d & valid_e & mem_read_e & (rd_e!=0) & ((use_rs1 & rs1==rd_e) | (use_rs2 & rs2==rd_e)).
- FSM, two states:
  - RUN: stall_f=stall_d=hz. If hz & !flush_e, go to STALL. ID/EX loads a bubble (valid_e=0, all controls 0, rd_e=0).
  - STALL: stall outputs 0. ID/EX loads the held instruction. Always returns to RUN. Latency of a load-use: exactly one bubble.
- ID/EX register update, each cycle, in priority order:
  1. flush_e: bubble; stall_f/stall_d forced 0; FSM to RUN.
  2. hz in RUN: bubble.
  3. Otherwise: decoded controls, rd_e=instr_d[11:7], valid_e=valid_d & !illegal_d.
- Illegal or !valid_d: loads a bubble.
- Reset (asynchronous, any time, including mid-stall): FSM=RUN, all registered outputs 0, stall_cnt 0. Stall outputs are 0 during reset.
- Back-to-back loads with a dependent chain each produce exactly one bubble.
- rd_e=x0 never causes a stall.

Optional Feature:
- STALL_COUNT_EN
- Defined: stall_cnt increments by 1 on every cycle where stall_d=1, saturating at all-ones with no wrap. Cleared only by rst.
- Undefined: the counter is absent and stall_cnt is tied to 0.

Test Plan:
- Decode/pack: instr_d=0xFE010EE3 (beq, imm -4) -> ImmSrc=010, ins_immediate=0x01FFC, branch_e=1 next cycle.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> stall_f=stall_d=1 for exactly one cycle; one bubble (valid_e=0); add reaches EX two cycles after lw.
- No false stall:
  - lw x0 followed by a use of x0 -> no stall.
  - lw x5 followed by lui x5 -> no stall (rs unused).
- Flush priority: hazard and flush_e=1 in the same cycle -> stall outputs 0, bubble loaded, FSM in RUN, no stall next cycle.
- Reset mid-stall: assert rst while stall_d=1 -> all outputs 0 immediately (async); after release, a normal addi decodes with ImmSrc=000.
- STALL_COUNT_EN: 3 load-use pairs -> stall_cnt=3. Force CNT_W=2 with 5 stalls -> stall_cnt holds at 3.
